// File: rtl/regfile_pkg.sv
// Shared defaults, opcode encodings and sequencer state encoding for the
// register-file operation sequencer.
package regfile_pkg;

    localparam int RF_DW    = 18;
    localparam int RF_AW    = 4;
    localparam int RF_NREGS = 9;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_MOV  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_SHL1 = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERR   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/regfile_op_sequencer_if.sv
// Command handshake bundle between decode logic (master) and the
// register-file operation sequencer (slave).
interface regfile_op_sequencer_if
    import regfile_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_rs1;
    logic [AW-1:0] cmd_rs2;
    logic [DW-1:0] cmd_imm;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output cmd_ready
    );
endinterface

// File: rtl/regfile_seq_alu.sv
// Combinational ALU for the sequencer: result and carry/borrow only; the
// zero flag is derived by the parent.
module regfile_seq_alu
    import regfile_pkg::*;
#(
    parameter int DW = RF_DW
) (
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y,
    output logic          c
);

    logic [DW:0] wide;

    always_comb begin
        wide = '0;
        y    = a;
        c    = 1'b0;
        case (op)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                y    = wide[DW-1:0];
                c    = wide[DW];
            end
            // The extra top bit of the widened difference is the unsigned borrow.
            OP_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                y    = wide[DW-1:0];
                c    = wide[DW];
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SHL1: begin
                y = {a[DW-2:0], 1'b0};
                c = a[DW-1];
            end
            default: y = a;
        endcase
    end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Sequences one register operation per command: read operands, execute,
// then a single-cycle write-back into the two-read/one-write register file.
module regfile_op_sequencer
    import regfile_pkg::*;
#(
    parameter int DW    = RF_DW,
    parameter int AW    = RF_AW,
    parameter int NREGS = RF_NREGS
) (
    input  logic                   clock,
    input  logic                   rst_n,
    regfile_op_sequencer_if.slave  cmd,
    output logic [AW-1:0]          rf_rs1,
    output logic [AW-1:0]          rf_rs2,
    input  logic [DW-1:0]          rf_rd1,
    input  logic [DW-1:0]          rf_rd2,
    output logic [AW-1:0]          rf_wa,
    output logic [DW-1:0]          rf_wd,
    output logic                   rf_wr_en,
    output logic                   done,
    output logic                   err,
    output logic [DW-1:0]          result,
    output logic                   flag_c,
    output logic                   flag_z
);

    seq_state_e    state_q, state_d;
    logic [2:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] opa_q, opb_q;
    logic [DW-1:0] alu_y;
    logic          alu_c;
    logic          accept;
    logic          cmd_illegal;

    function automatic logic addr_bad(input logic [AW-1:0] a);
        return {{(32-AW){1'b0}}, a} >= NREGS;
    endfunction

    function automatic logic uses_rs2(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

    // Only addresses the opcode actually uses can make a command illegal.
    assign cmd_illegal = addr_bad(cmd.cmd_rd) ||
                         ((cmd.cmd_op != OP_LOAD) && addr_bad(cmd.cmd_rs1)) ||
                         (uses_rs2(cmd.cmd_op) && addr_bad(cmd.cmd_rs2));

    assign accept = cmd.cmd_valid && (state_q == ST_IDLE);

    regfile_seq_alu #(.DW(DW)) u_alu (
        .op (op_q),
        .a  (opa_q),
        .b  (opb_q),
        .y  (alu_y),
        .c  (alu_c)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        cmd.cmd_ready = 1'b0;
        rf_wr_en      = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd.cmd_ready = 1'b1;
                if (cmd.cmd_valid) begin
                    if (cmd_illegal)                state_d = ST_ERR;
                    else if (cmd.cmd_op == OP_LOAD) state_d = ST_WRITE;
                    else                            state_d = ST_READ;
                end
            end
            ST_READ:  state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WRITE;
            ST_WRITE: begin
                rf_wr_en = 1'b1;
                done     = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_ERR: begin
                done    = 1'b1;
                err     = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write port and visible status are loaded on the edge entering WRITE, so
    // they are valid for the whole write cycle and hold afterwards.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            rd_q   <= '0;
            rf_rs1 <= '0;
            rf_rs2 <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            rf_wa  <= '0;
            rf_wd  <= '0;
            result <= '0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= cmd.cmd_op;
                rd_q   <= cmd.cmd_rd;
                rf_rs1 <= cmd.cmd_rs1;
                rf_rs2 <= cmd.cmd_rs2;
            end
            if (state_q == ST_READ) begin
                opa_q <= rf_rd1;
                opb_q <= rf_rd2;
            end
            if (accept && !cmd_illegal && (cmd.cmd_op == OP_LOAD)) begin
                rf_wa  <= cmd.cmd_rd;
                rf_wd  <= cmd.cmd_imm;
                result <= cmd.cmd_imm;
                flag_c <= 1'b0;
                flag_z <= (cmd.cmd_imm == '0);
            end else if (state_q == ST_EXEC) begin
                rf_wa  <= rd_q;
                rf_wd  <= alu_y;
                result <= alu_y;
                flag_c <= alu_c;
                flag_z <= (alu_y == '0);
            end
        end
    end

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Command-driven initiator for the 9-entry x 18-bit two-read/one-write register file.
- Accepts one register operation per valid/ready handshake, drives the read selects, and captures both read operands.
- Computes the result and issues a single-cycle write-back on the write port.
- Sits between the control/decode logic and the register file; it is the only driver of the file's RS1/RS2/WA/WD/wrEN.

Parameters:
- DW, 18, data width of register file and immediate
- AW, 4, register address width
- NREGS, 9, number of implemented registers (legal addresses 0..NREGS-1)

Ports:
- clock  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  operation code
- cmd_rd  in  AW  destination register
- cmd_rs1  in  AW  source register 1
- cmd_rs2  in  AW  source register 2
- cmd_imm  in  DW  immediate for LOAD
- rf_rs1  out  AW  register file read select 1
- rf_rs2  out  AW  register file read select 2
- rf_rd1  in  DW  register file read data 1 (combinational from rf_rs1)
- rf_rd2  in  DW  register file read data 2
- rf_wa  out  AW  register file write address
- rf_wd  out  DW  register file write data
- rf_wr_en  out  1  register file write enable
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: illegal register address, no write performed
- result  out  DW  value written (held until next done)
- flag_c  out  1  carry/borrow of last completed op
- flag_z  out  1  result == 0 of last completed op

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE immediately.
  - rf_wr_en=0, done=0, err=0, result=0, flag_c=0, flag_z=0.
  - rf_rs1=rf_rs2=rf_wa=0, rf_wd=0.
  - All latched command fields are cleared.
  - Reset mid-operation aborts the operation: no write occurs and no done pulse is issued.
- cmd_ready = 1 only in state IDLE. A command is accepted on a rising edge with cmd_valid && cmd_ready && rst_n. All cmd_* fields are latched at acceptance.
- Opcodes:
  - 0 LOAD: rd = imm
  - 1 MOV: rd = rs1
  - 2 ADD: rd = rs1 + rs2, flag_c = bit DW of the DW+1-bit sum
  - 3 SUB: rd = rs1 - rs2 mod 2^DW, flag_c = 1 when rs1 < rs2 (unsigned)
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 SHL1: rd = rs1 << 1, flag_c = rs1[DW-1]
  - flag_c = 0 for LOAD, MOV, AND, OR, XOR.
- States and transitions:
  - IDLE -> ERR, on accept, if any used address is >= NREGS. Used addresses: rd always; rs1 for all ops except LOAD; rs2 for ADD/SUB/AND/OR/XOR.
  - IDLE -> WRITE, on accept of a legal LOAD.
  - IDLE -> READ, on accept of any other legal op.
  - READ: rf_rs1/rf_rs2 driven from the latched fields; rf_rd1/rf_rd2 captured into operand registers at the end of the cycle. -> EXEC.
  - EXEC: ALU result and flags registered. -> WRITE.
  - WRITE: rf_wr_en=1 for exactly this cycle, with rf_wa=rd and rf_wd=result. done=1; result/flag_c/flag_z updated to the written values. -> IDLE.
  - ERR: done=1, err=1 for one cycle; no write; result and flags unchanged. -> IDLE.
- Latency, counted from the accept edge as cycle 0:
  - ALU ops: write/done in cycle 3.
  - LOAD: write/done in cycle 1.
  - Error: done in cycle 1.
- Throughput: one command per 4 cycles (ALU op) or 2 cycles (LOAD).
- The write commits at the edge ending WRITE. A command accepted in the following IDLE cycle reads the updated value, so no bypass is needed.
- Outside WRITE: rf_wr_en=0; rf_wa/rf_wd hold their last value.
- rd == rs1 or rd == rs2 is legal: operands are captured before the write.
- cmd_valid held high continuously is accepted back-to-back whenever IDLE is reached.

Decomposition:
- Shared package regfile_pkg holds:
  - DW/AW/NREGS defaults
  - opcode constants OP_LOAD..OP_SHL1
  - state encoding ST_IDLE, ST_READ, ST_EXEC, ST_WRITE, ST_ERR
- One combinational sub-module, regfile_seq_alu: inputs op, a, b; outputs y[DW-1:0], c. The zero flag is computed in the parent.

Test Plan:
- Reset mid-operation: assert rst_n=0 during EXEC of an ADD -> rf_wr_en never goes high, done=0, cmd_ready=1 after release, earlier register contents are not changed by the aborted op.
- LOAD r1=18'h2A02A, then LOAD r2=18'h00006 -> each LOAD: rf_wr_en high with done one cycle after accept; rf_wa=1 then 2; result=18'h2A02A then 18'h00006.
- ADD r3=r1+r2 -> wr_en/done 3 cycles after accept, rf_wd=18'h2A030, flag_c=0, flag_z=0.
- ADD with r1=18'h3FFFF, r2=1 -> result=0, flag_c=1, flag_z=1.
- SUB r4=r2-r1 with r2=6, r1=7 -> result=18'h3FFFF, flag_c=1.
- Illegal address: ADD rd=9 -> done=1 and err=1 one cycle after accept, rf_wr_en stays 0, result unchanged.
- Back-to-back: cmd_valid held high with 3 commands; MOV r5=r5 after LOAD r5=18'h12345 -> cmd_ready low during each op; MOV writes 18'h12345.
